// File: rtl/modport_counter_pkg.sv
// rtl/modport_counter_pkg.sv - shared width default and direction encoding for modport_counter
package modport_counter_pkg;

    localparam int WIDTH_DEFAULT = 4;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_t;

endpackage

// File: rtl/modport_counter.sv
// rtl/modport_counter.sv - loadable up/down counter with async active-low reset
module modport_counter
    import modport_counter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    input  logic             up_down,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] STEP = WIDTH'(1);

    logic [WIDTH-1:0] next_count;

    // WIDTH-bit add/subtract wraps naturally at both ends.
    always_comb begin
        next_count = count;
        if (load) begin
            next_count = din;
        end else if (dir_t'(up_down) == DIR_UP) begin
            next_count = count + STEP;
        end else begin
            next_count = count - STEP;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else begin
            count <= next_count;
        end
    end

endmodule

// File: tb/tb_modport_counter.sv
// tb/tb_modport_counter.sv - scoreboard bench for modport_counter
module tb_modport_counter;
    import modport_counter_pkg::*;

    localparam int WIDTH = WIDTH_DEFAULT;

    typedef struct {
        int               due;
        logic [WIDTH-1:0] exp;
    } sb_t;

    logic             clock;
    logic             resetn;
    logic [WIDTH-1:0] din;
    logic             load;
    logic             up_down;
    logic [WIDTH-1:0] count;

    int               checks;
    int               errors;
    int               cyc;
    logic [WIDTH-1:0] model;
    sb_t              q[$];

    modport_counter #(.WIDTH(WIDTH)) dut (
        .clock   (clock),
        .resetn  (resetn),
        .din     (din),
        .load    (load),
        .up_down (up_down),
        .count   (count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Monitor: samples 1 time unit before each rising edge.
    initial begin
        sb_t e;
        cyc = 0;
        forever begin
            @(posedge clock);
            cyc++;
            #9;
            while (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                checks++;
                if (count !== e.exp) begin
                    errors++;
                    $display("FAIL count cycle %0d: got %0d expected %0d", cyc, count, e.exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Driver: applies inputs 1 time unit after the edge and pushes the model's next value.
    task automatic drive(input logic rst, input logic ld, input logic [WIDTH-1:0] d,
                         input logic ud);
        sb_t e;
        @(posedge clock);
        #1;
        if (!rst && resetn) begin
            while (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (count !== e.exp) begin
                    errors++;
                    $display("FAIL count_before_reset: got %0d expected %0d", count, e.exp);
                end
            end
            resetn = 1'b0;
            #1;
            checks++;
            if (count !== '0) begin
                errors++;
                $display("FAIL async_reset: got %0d expected 0", count);
            end
        end
        resetn  = rst;
        load    = ld;
        din     = d;
        up_down = ud;
        if (!rst)    model = '0;
        else if (ld) model = d;
        else if (ud) model = model + WIDTH'(1);
        else         model = model - WIDTH'(1);
        e.due = cyc + 1;
        e.exp = model;
        q.push_back(e);
    endtask

    task automatic test_reset;
        resetn  = 1'b1;
        load    = 1'b0;
        din     = '0;
        up_down = DIR_UP;
        model   = '0;
        #2 resetn = 1'b0;
        #2;
        checks++;
        if (count !== '0) begin
            errors++;
            $display("FAIL reset_state: got %0d expected 0", count);
        end
        drive(1'b1, 1'b0, 4'd0, DIR_UP);
        drive(1'b1, 1'b1, 4'd5, DIR_UP);
        repeat (4) drive(1'b1, 1'b0, 4'd0, DIR_UP);
        drive(1'b0, 1'b0, 4'd0, DIR_UP);
        drive(1'b0, 1'b1, 4'd7, DIR_DOWN);
        drive(1'b1, 1'b0, 4'd0, DIR_UP);
        drive(1'b1, 1'b0, 4'd0, DIR_UP);
    endtask

    task automatic test_load;
        drive(1'b1, 1'b1, 4'hA, DIR_DOWN);
        repeat (3) drive(1'b1, 1'b0, 4'd0, DIR_UP);
    endtask

    task automatic test_up_wrap;
        drive(1'b1, 1'b1, 4'd14, DIR_UP);
        repeat (3) drive(1'b1, 1'b0, 4'd0, DIR_UP);
    endtask

    task automatic test_down_wrap;
        drive(1'b1, 1'b1, 4'd1, DIR_DOWN);
        repeat (3) drive(1'b1, 1'b0, 4'd0, DIR_DOWN);
    endtask

    task automatic test_load_priority;
        repeat (2) drive(1'b1, 1'b1, 4'd3, DIR_UP);
        drive(1'b1, 1'b1, 4'd3, DIR_DOWN);
    endtask

    task automatic test_random;
        for (int i = 0; i < 1200; i++) begin
            drive(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) == 0),
                  WIDTH'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_drain;
        drive(1'b1, 1'b0, 4'd0, DIR_UP);
        repeat (3) @(posedge clock);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", q.size());
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_load();
        test_up_wrap();
        test_down_wrap();
        test_load_priority();
        test_random();
        test_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/modport_counter.md
MODPORT_COUNTER -- requirements
Module: modport_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the counter and data width in bits.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port din, input, WIDTH bits: parallel load value.
REQ-005 SHALL have port load, input, 1 bit: synchronous load enable, active-high.
REQ-006 SHALL have port up_down, input, 1 bit: direction select; 1 = count up, 0 = count down.
REQ-007 SHALL have port count, output, WIDTH bits: registered counter value.

Function
REQ-008 SHALL drive count directly from a register, with no combinational path from any input to count.
REQ-009 SHALL, on a rising clock edge with resetn=1 and load=1, set count to din, ignoring up_down.
REQ-010 SHALL, on a rising clock edge with resetn=1, load=0 and up_down=1, set count to count+1 modulo 2^WIDTH.
REQ-011 SHALL, on a rising clock edge with resetn=1, load=0 and up_down=0, set count to count-1 modulo 2^WIDTH.
REQ-012 SHALL wrap from 2^WIDTH-1 (15 at default width) to 0 when counting up, with no flag, stall or saturation.
REQ-013 SHALL wrap from 0 to 2^WIDTH-1 when counting down.
REQ-014 SHALL have a latency of one clock: the effect of inputs sampled at edge N is visible on count after edge N.
REQ-015 SHALL count continuously every cycle when load=0; there is no hold or enable state.
REQ-016 SHALL give load priority over counting when load and up_down are both active in the same cycle.
REQ-017 SHALL have no handshake; every rising edge is a valid cycle.
REQ-018 SHALL treat X or Z on load or up_down as don't-care for synthesis; the bench must never drive them.

Reset
REQ-019 SHALL force count to 0 immediately when resetn falls, independent of clock.
REQ-020 SHALL hold count at 0 for as long as resetn=0, ignoring load, din and up_down.
REQ-021 SHALL resume loading or counting on the first rising edge after resetn rises; the first update is 0+1, 0-1 (= 2^WIDTH-1) or din.
REQ-022 SHALL force count to 0 even when resetn asserts mid-count or in the same cycle as a load.

Structure
REQ-023 SHALL place the WIDTH default constant and a direction typedef (DIR_DOWN=0, DIR_UP=1) in a shared package, modport_counter_pkg, which is imported by the RTL and the bench.
REQ-024 SHALL implement the logic in the single module modport_counter with one sequential process; no sub-module is required.
REQ-025 SHALL compute the next-state value with WIDTH-bit arithmetic so that wrap-around is inherent, with no explicit compare.

Verification
REQ-026 SHALL cover reset: assert resetn=0 mid-count at value 9 -> count=0 immediately; release resetn with load=0, up_down=1 -> count reads 1 after the next edge.
REQ-027 SHALL cover load: load=1, din=4'hA -> count=10 after one edge; then load=0, up_down=1 for three edges -> 11, 12, 13.
REQ-028 SHALL cover up wrap: load din=14, then up_down=1 -> 15, 0, 1 on successive edges.
REQ-029 SHALL cover down wrap: load din=1, then up_down=0 -> 0, 15, 14 on successive edges.
REQ-030 SHALL cover load priority: load=1, din=3, up_down=1 held for two edges -> count stays 3, with no increment.
REQ-031 SHALL cover random regression: at least 1000 cycles of random din, load and up_down with occasional resetn pulses, checked against a reference model (load, then ±1 modulo 16); the driver SHALL drive inputs 1 time unit after the edge and the monitor SHALL sample 1 time unit before the edge.
